// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Brief    : Multi-cycle wide adder/subtractor, one 32-bit slice per cycle.
// Revision : 1.0
// ============================================================================

module wide_add_csa (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  assign overflow    = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

module wide_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*NWORDS-1:0] a,
  input  logic [32*NWORDS-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NWORDS-1:0] sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 busy
);

  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_run  = 2'd1;
  localparam logic [1:0]    c_done = 2'd2;
  localparam logic [KW-1:0] c_last = KW'(NWORDS - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [KW-1:0] r_k;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;
  logic [31:0]   r_a_w   [NWORDS];
  logic [31:0]   r_b_w   [NWORDS];
  logic [31:0]   r_sum_w [NWORDS];

  logic [31:0]   w_csa_sum;
  logic          w_csa_cout;
  logic          w_csa_ovf;
  logic          w_accept;
  logic          w_step;
  logic          w_last;

  assign w_accept = (r_state == c_idle) && in_valid;
  assign w_step   = (r_state == c_run);
  assign w_last   = (r_k == c_last);

  wide_add_csa u_csa (
    .a        (r_a_w[r_k]),
    .b        (r_b_w[r_k]),
    .cin      (r_carry),
    .sum      (w_csa_sum),
    .cout     (w_csa_cout),
    .overflow (w_csa_ovf)
  );

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_sum_words
      assign sum[32*gi +: 32] = r_sum_w[gi];
    end
  endgenerate

  assign cout     = r_cout;
  assign overflow = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (in_valid)  w_next = c_run;
      c_run:   if (w_last)    w_next = c_done;
      c_done:  if (out_ready) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_idle);
    out_valid = (r_state == c_done);
    busy      = (r_state == c_run) || (r_state == c_done);
  end

  // Subtraction is stored as a + ~b + 1 so the slice adder never needs a mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        r_a_w[i]   <= '0;
        r_b_w[i]   <= '0;
        r_sum_w[i] <= '0;
      end
    end else if (w_accept) begin
      r_k     <= '0;
      r_carry <= sub ? 1'b1 : cin;
      for (int i = 0; i < NWORDS; i++) begin
        r_a_w[i] <= a[32*i +: 32];
        r_b_w[i] <= sub ? ~b[32*i +: 32] : b[32*i +: 32];
      end
    end else if (w_step) begin
      r_sum_w[r_k] <= w_csa_sum;
      r_carry      <= w_csa_cout;
      if (w_last) begin
        r_cout <= w_csa_cout;
        r_ovf  <= w_csa_ovf;
        r_k    <= '0;
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_add_seq
// Brief    : Vector-table and scoreboard bench for wide_add_seq (NWORDS=4).
// Revision : 1.0
// ============================================================================

module tb_wide_add_seq;

  localparam int NWORDS = 4;
  localparam int W      = 32 * NWORDS;
  localparam int NVEC   = 11;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vt[NVEC];

  wide_add_seq #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full-width reference; signed overflow judged from the original operand signs.
  function automatic exp_t model(input vec_t v);
    exp_t         e;
    logic [W:0]   t;
    if (v.sub) t = {1'b0, v.a} + {1'b0, ~v.b} + 1'b1;
    else       t = {1'b0, v.a} + {1'b0, v.b} + v.cin;
    e.s  = t[W-1:0];
    e.co = t[W];
    if (v.sub) e.ov = (v.a[W-1] != v.b[W-1]) && (e.s[W-1] != v.a[W-1]);
    else       e.ov = (v.a[W-1] == v.b[W-1]) && (e.s[W-1] != v.a[W-1]);
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    sb.push_back('{v.s, v.co, v.ov});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~v.a; b = {$urandom, $urandom, $urandom, $urandom}; cin = ~v.cin; sub = ~v.sub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, NWORDS);
    e = sb.pop_front();
    chk("sum", sum, e.s);
    chk("cout", cout, e.co);
    chk("overflow", overflow, e.ov);
    chk("busy_done", busy, 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_sum", sum, e.s);
      chk("hold_cout", cout, e.co);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid  = (hold > 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_busy", busy, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    vec_t v;
    exp_t e;

    vt[0] = '{{W{1'b1}}, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0};
    vt[1] = '{{1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
    vt[2] = '{W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, W'(64'h1_0000_0000), 1'b0, 1'b0};
    vt[3] = '{W'(5), W'(7), 1'b1, 1'b1, {{(W-2){1'b1}}, 2'b10}, 1'b0, 1'b0};
    vt[4] = '{'0, '0, 1'b1, 1'b0, W'(1), 1'b0, 1'b0};
    vt[5] = '{W'(7), W'(5), 1'b0, 1'b1, W'(2), 1'b1, 1'b0};
    vt[6] = '{{1'b1, {(W-1){1'b0}}}, W'(1), 1'b0, 1'b1, {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1};
    for (int i = 7; i < NVEC; i++) begin
      v.a   = {$urandom, $urandom, $urandom, $urandom};
      v.b   = {$urandom, $urandom, $urandom, $urandom};
      v.cin = 1'($urandom);
      v.sub = i[0];
      e     = model(v);
      v.s   = e.s; v.co = e.co; v.ov = e.ov;
      vt[i] = v;
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vt[i], (i == 2) ? 3 : 0);
    end

    // Abort a request at k=2, then restart straight after reset release.
    @(negedge clk);
    a = {4{32'hA5A5_5A5A}}; b = {4{32'h1111_2222}}; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_sum", sum, '0);
    chk("midrun_rst_cout", cout, 0);
    chk("midrun_rst_ovf", overflow, 0);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    v = '{W'(12'h123), W'(12'h123), 1'b0, 1'b0, W'(12'h246), 1'b0, 1'b0};
    run_vec(v, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
